// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, NOP encoding and queue entry layout for the fetch front end
package fetch_pkg;
  localparam int PC_W_DEF = 32;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam logic [DATA_W_DEF-1:0] NOP = '0;
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc_plus1;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear having priority over push and pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC owner, imem issue and decode-facing instruction queue with redirect flush
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_en,
  input  logic [DATA_W-1:0]          imem_q,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [DATA_W-1:0]          dec_instr,
  output logic [PC_W-1:0]            dec_pc_plus1,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_target,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [PC_W-1:0] pc, inflight_pc;
  logic inflight, issue, pop, push;
  logic [PC_W+DATA_W-1:0] head;
  assign issue = ~reset & ~redirect_valid & ((q_count + CW'(inflight)) < FULL);
  assign push = inflight & ~redirect_valid & ~reset;
  assign imem_en = issue;
  assign imem_addr = pc[ADDR_W-1:0];
  assign dec_valid = (q_count != '0) & ~redirect_valid & ~reset;
  assign pop = dec_valid & dec_ready;
  assign dec_instr = dec_valid ? head[DATA_W-1:0] : DATA_W'(NOP);
  assign dec_pc_plus1 = dec_valid ? head[PC_W+DATA_W-1:DATA_W] : '0;
  assign q_full = q_count == FULL;
  // pc and the single outstanding read; redirect and reset drop any in-flight response
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + PC_W'(1);
        inflight_pc <= pc;
      end
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(PC_W + DATA_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(redirect_valid),
    .din({inflight_pc + PC_W'(1), imem_q}),
    .count(q_count),
    .head(head)
  );
endmodule
